vga_pixel_out_stage: RTL and testbench
======================================

// Module: vga_pixel_out_stage
// PURPOSE
//   Final pixel stage between the scene compositor (ball/shadow/letters/background) and the TinyVGA pins.
//   Takes 12-bit RGB (4b/channel) plus hsync/vsync/display_on/hpos/vpos from the sync generator.
//   Applies a frame-stepped brightness fade, reduces colour to 2b/channel and realigns sync to the pipeline.
//   Packs everything into the 8-bit uo_out pin order.
// PARAMETERS
//   FRAMES_PER_STEP  2   frame events per +/-1 brightness step (1..15)
//   LEVEL_MAX        16  full-brightness level; fixed at 16, scale is (c*level)>>4
// PORTS
//   clk         in   1   pixel clock
//   rst_n       in   1   reset; synchronous, active-low
//   hsync_in    in   1   horizontal sync from sync generator; polarity passed through unchanged
//   vsync_in    in   1   vertical sync from sync generator; polarity passed through unchanged
//   display_on  in   1   active-video qualifier
//   hpos        in   10  current pixel x
//   vpos        in   10  current pixel y
//   rgb_in      in   12  {R[3:0],G[3:0],B[3:0]} from compositor, same cycle as hpos/vpos
//   blank_req   in   1   1 = fade to black / stay black; 0 = fade in / stay shown
//   vga_out     out  8   {hsync,B[0],G[0],R[0],vsync,B[1],G[1],R[1]}
//   level       out  5   current brightness 0..16
//   fade_busy   out  1   1 while state is FADE_IN or FADE_OUT
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk): vga_out=0, level=0, state=BLACK, step counter=0, fade_busy=0, all pipeline regs=0.
// - Frame event: the cycle with hpos==0 && vpos==0. Level/state update on that clock edge only.
//   Pipeline stage S1 uses the level value held before the update.
// - Fade FSM (evaluated only on frame events):
//   - BLACK: blank_req=0 -> FADE_IN (step counter cleared); else stay.
//   - FADE_IN: blank_req=1 -> FADE_OUT; level preserved, counter cleared.
//     Else counter++; when counter reaches FRAMES_PER_STEP-1: level+1, counter=0; level becomes 16 -> SHOW.
//   - SHOW: blank_req=1 -> FADE_OUT (counter cleared); else stay.
//   - FADE_OUT: blank_req=0 -> FADE_IN. Else step as above with level-1; level becomes 0 -> BLACK.
//   - level never leaves 0..16. Changing blank_req between frame events has no effect until the next event.
// - Pipeline, latency exactly 2 clocks for every field:
//   - S1: each channel sc = (c*level)>>4, giving 4 bits (level 16 = identity).
//     Register sc, hpos[1:0], vpos[1:0], hsync, vsync, display_on.
//   - S2: quantise sc to 2 bits, force colour to 0 if S1 display_on=0, pack into vga_out.
//   - Sync bits in vga_out equal hsync_in/vsync_in from 2 cycles earlier.
// - Reset mid-operation: all state cleared on that edge. The first 2 cycles after release output vga_out=0.
// CONFIGURATION
//   DITHER_EN defined:
//     q = min(15, sc + (bayer[vpos1][hpos1]>>2))[3:2], using the S1-registered low position bits.
//     Bayer 4x4 rows (vpos1=0..3, cols hpos1=0..3): 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5.
//   DITHER_EN undefined: q = sc[3:2] (plain truncation). Bayer table not built.
// TESTING
//   1 Reset release, blank_req=0, FRAMES_PER_STEP=2 -> level reaches 16 and state SHOW on exactly the 32nd frame event.
//     fade_busy=1 from frame event 1 through frame event 31.
//   2 level=16, display_on=1, rgb_in=12'hFFF at cycle N -> vga_out colour bits all 1 at N+2.
//     hsync_in pulse at N appears in vga_out[7] at N+2.
//   3 display_on=0, rgb_in=12'hFFF -> vga_out colour bits 0 two cycles later; sync bits still pass through.
//   4 DITHER_EN, level=16, R=4'd2, hpos=0,vpos=0 -> R=0.
//     Same with hpos=0,vpos=3 (bayer 15) -> R=2'b01. Without DITHER_EN both give 0.
//   5 During FADE_IN at level=7, assert blank_req before the next frame event.
//     -> FADE_OUT at that event with level 7, then level 6 two events later; level 0 -> BLACK.
//   6 Pull rst_n low for 1 cycle mid-FADE_OUT -> next cycle level=0, vga_out=0, fade_busy=0, state BLACK.

Source files
------------

// File: rtl/vga_pixel_out_stage.sv
//==============================================================================
// Module      : vga_pixel_out_stage
// Description : Final pixel stage before the TinyVGA pins. Applies a
//               frame-stepped brightness fade, reduces colour to 2 bits per
//               channel, keeps sync aligned with the 2-clock pipeline and packs
//               {hsync,B0,G0,R0,vsync,B1,G1,R1} onto vga_out.
//               Optional macro: DITHER_EN (4x4 ordered dither before
//               quantisation; plain truncation when undefined).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_pixel_out_stage #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int LEVEL_MAX       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        display_on,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic [11:0] rgb_in,
    input  logic        blank_req,
    output logic [7:0]  vga_out,
    output logic [4:0]  level,
    output logic        fade_busy
);

    typedef enum logic [1:0] {
        ST_BLACK    = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_SHOW     = 2'd2,
        ST_FADE_OUT = 2'd3
    } state_t;

    localparam logic [4:0] c_level_max = 5'(LEVEL_MAX);
    localparam logic [3:0] c_cnt_last  = 4'(FRAMES_PER_STEP - 1);

    state_t      state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [3:0]  sc_r_q, sc_g_q, sc_b_q, sc_r_d, sc_g_d, sc_b_d;
    logic        hs1_q, vs1_q, de1_q;
    logic [7:0]  vga_out_q, vga_out_d;

    logic        w_frame_event;
    logic [3:0]  w_cnt_next;
    logic        w_step;

`ifdef DITHER_EN
    logic [1:0]  hp1_q, vp1_q;

    // 4x4 Bayer threshold, row = vpos[1:0], column = hpos[1:0]
    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: return 4'd0;   4'h1: return 4'd8;   4'h2: return 4'd2;   4'h3: return 4'd10;
            4'h4: return 4'd12;  4'h5: return 4'd4;   4'h6: return 4'd14;  4'h7: return 4'd6;
            4'h8: return 4'd3;   4'h9: return 4'd11;  4'hA: return 4'd1;   4'hB: return 4'd9;
            4'hC: return 4'd15;  4'hD: return 4'd7;   4'hE: return 4'd13;  default: return 4'd5;
        endcase
    endfunction

    // Add a quarter of the threshold, saturate at 15, keep the top two bits
    function automatic logic [1:0] quant(input logic [3:0] sc, input logic [1:0] row,
                                         input logic [1:0] col);
        logic [4:0] sum;
        sum = {1'b0, sc} + 5'(bayer(row, col) >> 2);
        return sum[4] ? 2'b11 : 2'(sum >> 2);
    endfunction
`endif

    assign w_frame_event = (hpos == 10'd0) && (vpos == 10'd0);
    // The counter wraps after reaching the last value, so the first step of a
    // fade comes FRAMES_PER_STEP-1 events after entry and then every
    // FRAMES_PER_STEP events.
    assign w_cnt_next    = (cnt_q == c_cnt_last) ? 4'd0 : cnt_q + 4'd1;
    assign w_step        = (w_cnt_next == c_cnt_last);

    assign level     = level_q;
    assign fade_busy = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);
    assign vga_out   = vga_out_q;

    // Fade FSM next-state: evaluated only on frame events
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (w_frame_event) begin
            case (state_q)
                ST_BLACK: begin
                    if (!blank_req) begin
                        state_d = ST_FADE_IN;
                        cnt_d   = 4'd0;
                    end
                end
                ST_FADE_IN: begin
                    if (blank_req) begin
                        state_d = ST_FADE_OUT;
                        cnt_d   = 4'd0;
                    end else if (level_q >= c_level_max) begin
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = w_cnt_next;
                        if (w_step) begin
                            level_d = level_q + 5'd1;
                            if (level_q + 5'd1 == c_level_max) state_d = ST_SHOW;
                        end
                    end
                end
                ST_SHOW: begin
                    if (blank_req) begin
                        state_d = ST_FADE_OUT;
                        cnt_d   = 4'd0;
                    end
                end
                ST_FADE_OUT: begin
                    if (!blank_req) begin
                        state_d = ST_FADE_IN;
                        cnt_d   = 4'd0;
                    end else if (level_q == 5'd0) begin
                        state_d = ST_BLACK;
                    end else begin
                        cnt_d = w_cnt_next;
                        if (w_step) begin
                            level_d = level_q - 5'd1;
                            if (level_q == 5'd1) state_d = ST_BLACK;
                        end
                    end
                end
                default: state_d = ST_BLACK;
            endcase
        end
    end

    // Stage 1: scale each channel by the pre-update level, (c*level)>>4
    always_comb begin
        sc_r_d = 4'((9'(rgb_in[11:8]) * 9'(level_q)) >> 4);
        sc_g_d = 4'((9'(rgb_in[7:4])  * 9'(level_q)) >> 4);
        sc_b_d = 4'((9'(rgb_in[3:0])  * 9'(level_q)) >> 4);
    end

    // Stage 2: quantise to 2 bits, blank outside active video, pack pin order
    always_comb begin
        logic [1:0] q_r, q_g, q_b;
`ifdef DITHER_EN
        q_r = quant(sc_r_q, vp1_q, hp1_q);
        q_g = quant(sc_g_q, vp1_q, hp1_q);
        q_b = quant(sc_b_q, vp1_q, hp1_q);
`else
        q_r = 2'(sc_r_q >> 2);
        q_g = 2'(sc_g_q >> 2);
        q_b = 2'(sc_b_q >> 2);
`endif
        if (!de1_q) begin
            q_r = 2'b00;
            q_g = 2'b00;
            q_b = 2'b00;
        end
        vga_out_d = {hs1_q, q_b[0], q_g[0], q_r[0], vs1_q, q_b[1], q_g[1], q_r[1]};
    end

    // State, stage-1 and stage-2 registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BLACK;
            level_q   <= 5'd0;
            cnt_q     <= 4'd0;
            sc_r_q    <= 4'd0;
            sc_g_q    <= 4'd0;
            sc_b_q    <= 4'd0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            vga_out_q <= 8'd0;
`ifdef DITHER_EN
            hp1_q     <= 2'd0;
            vp1_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            sc_r_q    <= sc_r_d;
            sc_g_q    <= sc_g_d;
            sc_b_q    <= sc_b_d;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            de1_q     <= display_on;
            vga_out_q <= vga_out_d;
`ifdef DITHER_EN
            hp1_q     <= hpos[1:0];
            vp1_q     <= vpos[1:0];
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_out_stage.sv
//==============================================================================
// Module      : tb_vga_pixel_out_stage
// Description : Self-checking bench for vga_pixel_out_stage. A behavioural
//               model (integer arithmetic, one-deep delay slot) predicts
//               vga_out/level/fade_busy every cycle; directed literals pin it.
//               Honours DITHER_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_pixel_out_stage;

    localparam int FPS  = 2;
    localparam int H    = 8;   // short synthetic lines keep frames cheap
    localparam int V    = 4;
    localparam int M_BLACK = 0, M_FIN = 1, M_SHOW = 2, M_FOUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, display_on = 1'b0;
    logic [9:0]  hpos = 10'd5, vpos = 10'd1;
    logic [11:0] rgb_in = 12'd0;
    logic        blank_req = 1'b0;
    logic [7:0]  vga_out;
    logic [4:0]  level;
    logic        fade_busy;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int         m_lvl = 0, m_st = M_BLACK, m_n = 0;
    logic [7:0] m_d1 = 8'd0, m_vga = 8'd0;

`ifdef DITHER_EN
    int bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
`endif

    vga_pixel_out_stage #(.FRAMES_PER_STEP(FPS), .LEVEL_MAX(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .rgb_in     (rgb_in),
        .blank_req  (blank_req),
        .vga_out    (vga_out),
        .level      (level),
        .fade_busy  (fade_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected packed pixel for one input sample at a given brightness
    function automatic logic [7:0] pix(input int lvl, input logic [11:0] rgb, input logic de,
                                       input logic hs, input logic vs,
                                       input logic [9:0] hp, input logic [9:0] vp);
        logic [1:0] q [3];
        for (int i = 0; i < 3; i++) begin
            int ch, t;
            ch = int'((rgb >> (8 - 4 * i)) & 12'hF);
            t  = (ch * lvl) / 16;
`ifdef DITHER_EN
            t = t + bayer[int'(vp[1:0]) * 4 + int'(hp[1:0])] / 4;
            if (t > 15) t = 15;
`endif
            q[i] = de ? 2'(t / 4) : 2'b00;
        end
        return {hs, q[2][0], q[1][0], q[0][0], vs, q[2][1], q[1][1], q[0][1]};
    endfunction

    task automatic model_fade();
        case (m_st)
            M_BLACK: if (!blank_req) begin m_st = M_FIN; m_n = 0; end
            M_FIN: begin
                if (blank_req) begin m_st = M_FOUT; m_n = 0; end
                else if (m_lvl >= 16) m_st = M_SHOW;
                else begin
                    m_n++;
                    if ((m_n + 1) % FPS == 0) begin
                        m_lvl++;
                        if (m_lvl == 16) m_st = M_SHOW;
                    end
                end
            end
            M_SHOW: if (blank_req) begin m_st = M_FOUT; m_n = 0; end
            default: begin
                if (!blank_req) begin m_st = M_FIN; m_n = 0; end
                else if (m_lvl == 0) m_st = M_BLACK;
                else begin
                    m_n++;
                    if ((m_n + 1) % FPS == 0) begin
                        m_lvl--;
                        if (m_lvl == 0) m_st = M_BLACK;
                    end
                end
            end
        endcase
    endtask

    // One clock: advance the model on the edge, then compare after settling
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_lvl = 0; m_st = M_BLACK; m_n = 0; m_d1 = 8'd0; m_vga = 8'd0;
        end else begin
            m_vga = m_d1;
            m_d1  = pix(m_lvl, rgb_in, display_on, hsync_in, vsync_in, hpos, vpos);
            if (hpos == 10'd0 && vpos == 10'd0) model_fade();
        end
        #1;
        check("vga_out", int'(vga_out), int'(m_vga));
        check("level", int'(level), m_lvl);
        check("fade_busy", int'(fade_busy), int'(m_st == M_FIN || m_st == M_FOUT));
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int v = 0; v < V; v++)
                for (int h = 0; h < H; h++) begin
                    hpos       = 10'(h);
                    vpos       = 10'(v);
                    hsync_in   = (h >= 6);
                    vsync_in   = (v == 3);
                    display_on = (h < 5) && (v < 3);
                    rgb_in     = 12'($urandom);
                    step();
                end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hpos = 10'd5; vpos = 10'd1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset();
        check("reset_vga", int'(vga_out), 0);
        check("reset_level", int'(level), 0);
        check("reset_busy", int'(fade_busy), 0);

        // fade in from reset: level 16 exactly on event 32
        blank_req = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            run_frames(1);
            if (e == 1)  begin check("ev1_busy", int'(fade_busy), 1); check("ev1_level", int'(level), 0); end
            if (e == 2)  check("ev2_level", int'(level), 1);
            if (e == 31) begin check("ev31_busy", int'(fade_busy), 1); check("ev31_level", int'(level), 15); end
            if (e == 32) begin check("ev32_level", int'(level), 16); check("ev32_busy", int'(fade_busy), 0); end
        end

        // full white with sync pulse, two-cycle latency
        hpos = 10'd5; vpos = 10'd1; display_on = 1'b1;
        rgb_in = 12'hFFF; hsync_in = 1'b1; vsync_in = 1'b1;
        step();
        rgb_in = 12'h000; hsync_in = 1'b0; vsync_in = 1'b0;
        step();
        check("white_sync", int'(vga_out), 8'hFF);
        step();
        check("black_after", int'(vga_out), 8'h00);

        // display_on low blanks colour but keeps sync
        display_on = 1'b0; rgb_in = 12'hFFF; hsync_in = 1'b1;
        step();
        display_on = 1'b1; rgb_in = 12'h000; hsync_in = 1'b0;
        step();
        check("blanked_sync", int'(vga_out), 8'h80);

        // dither corner cases on red = 2 at level 16
        rgb_in = 12'h200; hpos = 10'd0; vpos = 10'd0;
        step();
        vpos = 10'd3;
        step();
        check("r2_bayer0", int'(vga_out), 8'h00);
        rgb_in = 12'h8C4; hpos = 10'd1; vpos = 10'd1;
        step();
`ifdef DITHER_EN
        check("r2_bayer15", int'(vga_out), 8'h10);
`else
        check("r2_bayer15", int'(vga_out), 8'h00);
`endif
        step();
        check("mix_8c4", int'(vga_out), 8'h63);

        // reversal during fade-in at level 7, then fade to black
        do_reset();
        blank_req = 1'b0;
        run_frames(14);
        check("fin_level7", int'(level), 7);
        blank_req = 1'b1;
        run_frames(1);
        check("rev_level", int'(level), 7);
        check("rev_busy", int'(fade_busy), 1);
        run_frames(2);
        check("rev_level6", int'(level), 6);
        run_frames(12);
        check("black_level", int'(level), 0);
        check("black_busy", int'(fade_busy), 0);

        // reset pulse mid fade-out
        blank_req = 1'b0;
        run_frames(6);
        blank_req = 1'b1;
        run_frames(2);
        check("fout_busy", int'(fade_busy), 1);
        hpos = 10'd3; vpos = 10'd2; display_on = 1'b1; rgb_in = 12'hFFF; hsync_in = 1'b1;
        rst_n = 1'b0;
        step();
        check("midrst_level", int'(level), 0);
        check("midrst_vga", int'(vga_out), 0);
        check("midrst_busy", int'(fade_busy), 0);
        rst_n = 1'b1;
        step();
        check("release_vga", int'(vga_out), 0);
        run_frames(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
